// File: rtl/serial_operand_shift_reg.sv
// Parallel-load, serial-out operand register for the bit-serial add/subtract datapath.
// Optionally stores the two's complement of the operand and tracks progress with Cnt/Busy/Done.
module serial_operand_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit SIGN_EXT  = 1'b0,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             L,
    input  logic [WIDTH-1:0] Load,
    input  logic             NEG,
    input  logic             SH,
    output logic             Sout,
    output logic             Busy,
    output logic             Done,
    output logic [CW-1:0]    Cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] ld_val;

    // Negation wraps modulo 2^WIDTH, so the most negative value maps to itself.
    assign ld_val = NEG ? (~Load + {{(WIDTH-1){1'b0}}, 1'b1}) : Load;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        if (L) begin
            data_d  = ld_val;
            cnt_d   = '0;
            state_d = ST_SHIFT;
            sign_d  = ld_val[WIDTH-1];
        end else if (state_q == ST_SHIFT && SH) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = ST_DONE;
            end
        end
    end

    // Outputs decode registered state only; no input reaches Sout combinationally.
    always_comb begin
        Sout = 1'b0;
        case (state_q)
            ST_SHIFT: Sout = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
            ST_DONE:  Sout = (SIGN_EXT && !MSB_FIRST) ? sign_q : 1'b0;
            default:  Sout = 1'b0;
        endcase
    end

    assign Busy = (state_q == ST_SHIFT);
    assign Done = (state_q == ST_DONE);
    assign Cnt  = cnt_q;

endmodule

// File: tb/tb_serial_operand_shift_reg.sv
// Directed bench for serial_operand_shift_reg: four configurations driven from shared controls.
module tb_serial_operand_shift_reg;

    logic        clk;
    logic        rst_n;
    logic        l_in;
    logic        neg_in;
    logic        sh_in;
    logic [7:0]  ld8;
    logic [15:0] ld16;

    logic       so_lsb, busy_lsb, done_lsb;
    logic [3:0] cnt_lsb;
    logic       so_sx, busy_sx, done_sx;
    logic [3:0] cnt_sx;
    logic       so_msb, busy_msb, done_msb;
    logic [3:0] cnt_msb;
    logic       so_w16, busy_w16, done_w16;
    logic [4:0] cnt_w16;

    int total = 0;
    int bad   = 0;

    serial_operand_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .SIGN_EXT(1'b0)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .L(l_in), .Load(ld8), .NEG(neg_in), .SH(sh_in),
        .Sout(so_lsb), .Busy(busy_lsb), .Done(done_lsb), .Cnt(cnt_lsb));

    serial_operand_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .SIGN_EXT(1'b1)) u_sx (
        .CLK(clk), .RST_N(rst_n), .L(l_in), .Load(ld8), .NEG(neg_in), .SH(sh_in),
        .Sout(so_sx), .Busy(busy_sx), .Done(done_sx), .Cnt(cnt_sx));

    serial_operand_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .SIGN_EXT(1'b0)) u_msb (
        .CLK(clk), .RST_N(rst_n), .L(l_in), .Load(ld8), .NEG(neg_in), .SH(sh_in),
        .Sout(so_msb), .Busy(busy_msb), .Done(done_msb), .Cnt(cnt_msb));

    serial_operand_shift_reg #(.WIDTH(16), .MSB_FIRST(1'b0), .SIGN_EXT(1'b0)) u_w16 (
        .CLK(clk), .RST_N(rst_n), .L(l_in), .Load(ld16), .NEG(neg_in), .SH(sh_in),
        .Sout(so_w16), .Busy(busy_w16), .Done(done_w16), .Cnt(cnt_w16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] v, input logic n);
        ld8    = v;
        neg_in = n;
        l_in   = 1'b1;
        tick();
        l_in   = 1'b0;
        neg_in = 1'b0;
    endtask

    logic [7:0]  exp8;
    logic [15:0] exp16;

    initial begin
        rst_n  = 1'b0;
        l_in   = 1'b0;
        neg_in = 1'b0;
        sh_in  = 1'b0;
        ld8    = 8'h00;
        ld16   = 16'h0000;
        #12;
        check("rst_sout", {31'd0, so_lsb}, 32'd0);
        check("rst_busy", {31'd0, busy_lsb}, 32'd0);
        check("rst_done", {31'd0, done_lsb}, 32'd0);
        check("rst_cnt", {28'd0, cnt_lsb}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LSB-first, 8'hA4: expected emission 0,0,1,0,0,1,0,1
        load8(8'b1010_0100, 1'b0);
        check("t1_busy", {31'd0, busy_lsb}, 32'd1);
        exp8 = 8'b1010_0100;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_sout%0d", i), {31'd0, so_lsb}, {31'd0, exp8[i]});
            check($sformatf("t1_cnt%0d", i), {28'd0, cnt_lsb}, i);
            sh_in = 1'b1;
            tick();
        end
        sh_in = 1'b0;
        check("t1_cnt_end", {28'd0, cnt_lsb}, 32'd8);
        check("t1_done", {31'd0, done_lsb}, 32'd1);
        check("t1_busy_end", {31'd0, busy_lsb}, 32'd0);
        check("t1_sout_done", {31'd0, so_lsb}, 32'd0);

        // Negated 5 -> 8'hFB, emission 1,1,0,1,1,1,1,1; sign held in DONE
        load8(8'd5, 1'b1);
        exp8 = 8'b1111_1011;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_sout%0d", i), {31'd0, so_sx}, {31'd0, exp8[i]});
            sh_in = 1'b1;
            tick();
        end
        check("t2_done", {31'd0, done_sx}, 32'd1);
        check("t2_sout_done", {31'd0, so_sx}, 32'd1);
        check("t2_nosx_sout_done", {31'd0, so_lsb}, 32'd0);
        tick();
        sh_in = 1'b0;
        check("t2_extra_sout", {31'd0, so_sx}, 32'd1);
        check("t2_extra_cnt", {28'd0, cnt_sx}, 32'd8);

        // MSB-first, 8'b01101101: emission 0,1,1,0,1,1,0,1
        load8(8'b0110_1101, 1'b0);
        exp8 = 8'b1011_0110;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_sout%0d", i), {31'd0, so_msb}, {31'd0, exp8[i]});
            sh_in = 1'b1;
            tick();
        end
        sh_in = 1'b0;
        check("t3_done", {31'd0, done_msb}, 32'd1);
        check("t3_cnt", {28'd0, cnt_msb}, 32'd8);

        // Reload mid-stream with SH also high: L wins
        load8(8'hA4, 1'b0);
        sh_in = 1'b1;
        tick(); tick(); tick();
        check("t4_cnt3", {28'd0, cnt_lsb}, 32'd3);
        ld8  = 8'h0F;
        l_in = 1'b1;
        tick();
        l_in = 1'b0;
        check("t4_cnt", {28'd0, cnt_lsb}, 32'd0);
        check("t4_busy", {31'd0, busy_lsb}, 32'd1);
        check("t4_sout", {31'd0, so_lsb}, 32'd1);
        tick();
        check("t4_cnt1", {28'd0, cnt_lsb}, 32'd1);
        tick();
        sh_in = 1'b0;
        check("t4_sout2", {31'd0, so_lsb}, 32'd1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_sout", {31'd0, so_lsb}, 32'd0);
        check("t5_busy", {31'd0, busy_lsb}, 32'd0);
        check("t5_done", {31'd0, done_lsb}, 32'd0);
        check("t5_cnt", {28'd0, cnt_lsb}, 32'd0);
        rst_n = 1'b1;
        sh_in = 1'b1;
        tick(); tick();
        sh_in = 1'b0;
        check("t5_sh_idle_cnt", {28'd0, cnt_lsb}, 32'd0);
        check("t5_sh_idle_busy", {31'd0, busy_lsb}, 32'd0);

        // 16-bit: -(16'h8000) wraps to 16'h8000; 15 zeros then a one
        ld16   = 16'h8000;
        neg_in = 1'b1;
        l_in   = 1'b1;
        tick();
        l_in   = 1'b0;
        neg_in = 1'b0;
        exp16  = 16'h8000;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_sout%0d", i), {31'd0, so_w16}, {31'd0, exp16[i]});
            sh_in = 1'b1;
            tick();
        end
        sh_in = 1'b0;
        check("t6_cnt", {27'd0, cnt_w16}, 32'd16);
        check("t6_done", {31'd0, done_w16}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
